// File: rtl/inst_mem_ctrl_if.sv
// Fetch and boot-loader bus between the core side and inst_mem_ctrl.
// INST_MEM_PARITY_EN adds the parity_err return signal.
interface inst_mem_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 12
);
    logic [AWIDTH-1:0] inst_addr;
    logic [XLEN-1:0]   inst_data;
    logic              inst_misalign;
    logic              inst_busy;
    logic              ld_valid;
    logic              ld_ready;
    logic [AWIDTH-1:0] ld_addr;
    logic [XLEN-1:0]   ld_data;
    logic              ld_last;
    logic              reload_req;
    logic [AWIDTH-2:0] ld_count;
`ifdef INST_MEM_PARITY_EN
    logic              inst_parity_err;
`endif

    modport slave (
        input  inst_addr, ld_valid, ld_addr, ld_data, ld_last, reload_req,
`ifdef INST_MEM_PARITY_EN
        output inst_parity_err,
`endif
        output inst_data, inst_misalign, inst_busy, ld_ready, ld_count
    );

    modport master (
        output inst_addr, ld_valid, ld_addr, ld_data, ld_last, reload_req,
`ifdef INST_MEM_PARITY_EN
        input  inst_parity_err,
`endif
        input  inst_data, inst_misalign, inst_busy, ld_ready, ld_count
    );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Instruction memory responder with 1-cycle synchronous read and boot-load path.
// Optional per-word even parity when INST_MEM_PARITY_EN is defined.
//
// state | meaning
// LOAD  | core held (inst_busy=1), loader beats accepted, reads return NOP
// RUN   | fetch reads served from memory, loader ignored
module inst_mem_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              AWIDTH   = 12,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_mem_ctrl_if.slave       bus
);
    localparam int DEPTH = 1 << (AWIDTH - 2);
    localparam int CNT_W = AWIDTH - 1;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              ld_ready;
    logic              inst_busy;
    logic [XLEN-1:0]   mem [0:DEPTH-1];
    logic [XLEN-1:0]   inst_data;
    logic              inst_misalign;
    logic [CNT_W-1:0]  ld_count;
    logic [AWIDTH-3:0] rd_idx;
    logic [AWIDTH-3:0] wr_idx;
    logic              unused_ld_lsb;

    assign rd_idx        = bus.inst_addr[AWIDTH-1:2];
    assign wr_idx        = bus.ld_addr[AWIDTH-1:2];
    assign unused_ld_lsb = ^bus.ld_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        inst_busy = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_LOAD: begin
                ld_ready  = 1'b1;
                inst_busy = 1'b1;
                accept    = bus.ld_valid;
                // ld_last beats a coincident reload_req: reload is ignored in LOAD.
                if (bus.ld_valid && bus.ld_last) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.reload_req) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Array is deliberately not reset so loaded code survives a core reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept) mem[wr_idx] <= bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_data     <= NOP_INST;
            inst_misalign <= 1'b0;
        end else if (state == ST_RUN) begin
            inst_data     <= mem[rd_idx];
            inst_misalign <= (bus.inst_addr[1:0] != 2'b00);
        end else begin
            inst_data     <= NOP_INST;
            inst_misalign <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ld_count <= '0;
        else if (state == ST_RUN && bus.reload_req)
            ld_count <= '0;
        else if (accept && ld_count != '1)
            ld_count <= ld_count + CNT_W'(1);
    end

`ifdef INST_MEM_PARITY_EN
    logic mem_par [0:DEPTH-1];
    logic inst_parity_err;

    always_ff @(posedge clk) begin
        if (rst_n && accept) mem_par[wr_idx] <= ^bus.ld_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            inst_parity_err <= 1'b0;
        else
            inst_parity_err <= (state == ST_RUN) && ((^mem[rd_idx]) != mem_par[rd_idx]);
    end

    assign bus.inst_parity_err = inst_parity_err;
`endif

    assign bus.inst_data     = inst_data;
    assign bus.inst_misalign = inst_misalign;
    assign bus.inst_busy     = inst_busy;
    assign bus.ld_ready      = ld_ready;
    assign bus.ld_count      = ld_count;
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed bench for inst_mem_ctrl; parity checks compile in with INST_MEM_PARITY_EN.
module tb_inst_mem_ctrl;
    localparam int          XLEN   = 32;
    localparam int          AWIDTH = 12;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    inst_mem_ctrl_if #(.XLEN(XLEN), .AWIDTH(AWIDTH)) bus_if ();

    inst_mem_ctrl #(.XLEN(XLEN), .AWIDTH(AWIDTH), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [11:0] a, input logic [31:0] d, input logic last);
        bus_if.ld_valid = 1'b1;
        bus_if.ld_addr  = a;
        bus_if.ld_data  = d;
        bus_if.ld_last  = last;
        tick();
        bus_if.ld_valid = 1'b0;
        bus_if.ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] a);
        bus_if.inst_addr = a;
        tick();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_if.inst_addr  = '0;
        bus_if.ld_valid   = 1'b0;
        bus_if.ld_addr    = '0;
        bus_if.ld_data    = '0;
        bus_if.ld_last    = 1'b0;
        bus_if.reload_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy",     32'(bus_if.inst_busy), 32'd1);
        check("rst_ready",    32'(bus_if.ld_ready), 32'd1);
        check("rst_data",     bus_if.inst_data, NOP);
        check("rst_count",    32'(bus_if.ld_count), 32'd0);
        check("rst_misalign", 32'(bus_if.inst_misalign), 32'd0);

        beat(12'h000, 32'h11111111, 1'b0);
        beat(12'h004, 32'h22222222, 1'b0);
        beat(12'h008, 32'h33333333, 1'b0);
        check("load3_count", 32'(bus_if.ld_count), 32'd3);
        check("load3_busy",  32'(bus_if.inst_busy), 32'd1);
        bus_if.inst_addr = 12'h008;
        beat(12'h00C, 32'h44444444, 1'b1);
        check("load4_count", 32'(bus_if.ld_count), 32'd4);
        check("run_busy",    32'(bus_if.inst_busy), 32'd0);
        check("run_ready",   32'(bus_if.ld_ready), 32'd0);
        check("run_first_data_nop", bus_if.inst_data, NOP);
        fetch(12'h008);
        check("fetch_008", bus_if.inst_data, 32'h33333333);

        fetch(12'h00A);
        check("mis_00A_data", bus_if.inst_data, 32'h33333333);
        check("mis_00A_flag", 32'(bus_if.inst_misalign), 32'd1);
        fetch(12'h00C);
        check("mis_00C_data", bus_if.inst_data, 32'h44444444);
        check("mis_00C_flag", 32'(bus_if.inst_misalign), 32'd0);

        // Beat offered in RUN must be ignored.
        bus_if.inst_addr = 12'h000;
        beat(12'h000, 32'hBADBAD00, 1'b1);
        check("run_beat_count", 32'(bus_if.ld_count), 32'd4);
        check("run_beat_busy",  32'(bus_if.inst_busy), 32'd0);
        fetch(12'h000);
        check("run_beat_nowrite", bus_if.inst_data, 32'h11111111);

        bus_if.reload_req = 1'b1;
        tick();
        bus_if.reload_req = 1'b0;
        check("reload_busy",  32'(bus_if.inst_busy), 32'd1);
        check("reload_ready", 32'(bus_if.ld_ready), 32'd1);
        check("reload_count", 32'(bus_if.ld_count), 32'd0);
        tick();
        check("reload_nop", bus_if.inst_data, NOP);
        bus_if.reload_req = 1'b1;
        tick();
        bus_if.reload_req = 1'b0;
        check("reload_in_load_busy", 32'(bus_if.inst_busy), 32'd1);

        beat(12'h008, 32'hCAFEF00D, 1'b0);
        check("stall_b1_count", 32'(bus_if.ld_count), 32'd1);
        bus_if.ld_addr  = 12'h00C;
        bus_if.ld_data  = 32'h55555555;
        bus_if.ld_last  = 1'b1;
        tick();
        bus_if.ld_last  = 1'b0;
        check("stall_gap_count", 32'(bus_if.ld_count), 32'd1);
        check("stall_gap_busy",  32'(bus_if.inst_busy), 32'd1);
        bus_if.reload_req = 1'b1;
        beat(12'h005, 32'hDEADBEEF, 1'b1);
        bus_if.reload_req = 1'b0;
        check("stall_b2_count", 32'(bus_if.ld_count), 32'd2);
        check("last_wins_busy", 32'(bus_if.inst_busy), 32'd0);
        fetch(12'h004);
        check("reload_004", bus_if.inst_data, 32'hDEADBEEF);
        fetch(12'h000);
        check("retained_000", bus_if.inst_data, 32'h11111111);
        fetch(12'h008);
        check("stall_008", bus_if.inst_data, 32'hCAFEF00D);
        fetch(12'h00C);
        check("gap_nowrite_00C", bus_if.inst_data, 32'h44444444);

`ifdef INST_MEM_PARITY_EN
        fetch(12'h004);
        check("par_clean", 32'(bus_if.inst_parity_err), 32'd0);
        dut.mem_par[1] = ~dut.mem_par[1];
        fetch(12'h004);
        check("par_err",      32'(bus_if.inst_parity_err), 32'd1);
        check("par_err_data", bus_if.inst_data, 32'hDEADBEEF);
        fetch(12'h000);
        check("par_err_clear", 32'(bus_if.inst_parity_err), 32'd0);
`endif

        rst_n = 1'b0;
        tick();
        check("runrst_busy",  32'(bus_if.inst_busy), 32'd1);
        check("runrst_data",  bus_if.inst_data, NOP);
        check("runrst_count", 32'(bus_if.ld_count), 32'd0);
        rst_n = 1'b1;
        tick();
        check("runrst_held", 32'(bus_if.inst_busy), 32'd1);

        beat(12'h010, 32'h77777777, 1'b0);
        beat(12'h014, 32'h88888888, 1'b0);
        check("midload_count2", 32'(bus_if.ld_count), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_count", 32'(bus_if.ld_count), 32'd0);
        check("midrst_busy",  32'(bus_if.inst_busy), 32'd1);
        check("midrst_ready", 32'(bus_if.ld_ready), 32'd1);
        beat(12'h018, 32'h99999999, 1'b1);
        check("midrst_count1", 32'(bus_if.ld_count), 32'd1);
        fetch(12'h010);
        check("midrst_kept_010", bus_if.inst_data, 32'h77777777);
        fetch(12'h018);
        check("midrst_new_018", bus_if.inst_data, 32'h99999999);

        bus_if.reload_req = 1'b1;
        tick();
        bus_if.reload_req = 1'b0;
        for (int i = 0; i < 2046; i++) beat(12'(i * 4), 32'(i), 1'b0);
        check("count_2046", 32'(bus_if.ld_count), 32'd2046);
        for (int i = 0; i < 4; i++) beat(12'(i * 4), 32'(i), 1'b0);
        check("count_sat", 32'(bus_if.ld_count), 32'd2047);
        beat(12'h020, 32'hA5A5A5A5, 1'b1);
        check("sat_last_count", 32'(bus_if.ld_count), 32'd2047);
        check("sat_last_busy",  32'(bus_if.inst_busy), 32'd0);
        fetch(12'h020);
        check("sat_fetch_020", bus_if.inst_data, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
- Responder side of the fetch/instruction-memory interface.
- Takes the byte address from the fetch phase and returns the instruction word one clock later, with the timing of a synchronous block RAM.
- Also contains a boot-load path: after reset, or on a reload request, it fills the memory from a loader over a valid/ready handshake. During that time it holds the core off with inst_busy.

Parameters:
- XLEN, 32, instruction/data word width.
- AWIDTH, 12, byte address width; memory depth is 2^(AWIDTH-2) words.
- NOP_INST, 32'h00000013, word returned while not in RUN (addi x0,x0,0).

Ports:
- clk  in  1  global clock
- rst_n  in  1  reset: synchronous, active-low; sampled on rising clk edge
- inst_addr  in  AWIDTH  fetch byte address
- inst_data  out  XLEN  instruction word, registered
- inst_misalign  out  1  registered flag: sampled inst_addr[1:0] != 0
- inst_busy  out  1  memory not in RUN; the state machine must hold the fetch phase
- ld_valid  in  1  loader beat valid
- ld_ready  out  1  controller accepts beat
- ld_addr  in  AWIDTH  loader byte address
- ld_data  in  XLEN  loader word
- ld_last  in  1  final beat of load, qualified by ld_valid
- reload_req  in  1  single-cycle request to re-enter LOAD from RUN
- ld_count  out  AWIDTH-1  number of beats accepted in current load

Behaviour:
- Reset, on the clk edge with rst_n=0:
  - state=LOAD, inst_data=NOP_INST, inst_misalign=0, inst_busy=1, ld_count=0.
  - ld_ready=1 from the first cycle after reset release.
  - Memory array is not reset; contents are retained across reset.
- States:
  - LOAD: inst_busy=1, ld_ready=1.
  - RUN: inst_busy=0, ld_ready=0.
- Beat acceptance: a beat is accepted when ld_valid && ld_ready at a rising edge.
  - Write mem[ld_addr[AWIDTH-1:2]] <= ld_data.
  - ld_addr[1:0] is ignored.
  - ld_count increments by 1 and saturates at all-ones (no wrap).
- LOAD -> RUN: on an accepted beat with ld_last=1.
  - inst_busy falls in the next cycle.
  - An address presented in that cycle returns data one cycle later.
- RUN -> LOAD: on reload_req=1.
  - ld_count clears to 0 at the same edge.
  - inst_busy and ld_ready rise in the next cycle.
  - reload_req in LOAD is ignored.
- Read port:
  - Every cycle, inst_data <= (state==RUN) ? mem[inst_addr[AWIDTH-1:2]] : NOP_INST.
  - Latency is exactly 1 clk; there is no read enable, so the address is sampled every cycle.
  - inst_misalign <= (inst_addr[1:0]!=0) in RUN, 0 otherwise.
  - Data is still returned from the word-aligned location.
- Read/write ordering: writes occur only in LOAD and reads return NOP in LOAD, so there is no read/write collision.
  - The first RUN read of a word written on the final beat returns the new data (write-first ordering is not needed).
- Beats while ld_ready=0 are not accepted and leave no side effects; the loader must hold the beat.
- Reset during LOAD: partially loaded words are kept, ld_count=0, load restarts in LOAD.
- Reset during RUN: returns to LOAD; the core stays held until a new ld_last beat.
- Simultaneous ld_last and reload_req in LOAD: ld_last wins and the state goes to RUN; reload_req is dropped.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from ld_data at write.
  - Added output inst_parity_err (1 bit, registered, reset 0): 1 in the cycle inst_data is presented if the stored parity mismatches in RUN; forced 0 in LOAD.
  - A parity error does not alter inst_data.
- When undefined: no parity storage, and no inst_parity_err port.

Test Plan:
- Reset release:
  - Cycle after reset: inst_busy=1, ld_ready=1, inst_data=32'h00000013, ld_count=0.
- Load and first fetch:
  - Load 4 beats to addrs 0x000,0x004,0x008,0x00C with data 0x11111111..0x44444444, ld_last on 4th.
  - ld_count=4, inst_busy=0 next cycle.
  - inst_addr=0x008 -> inst_data=0x33333333 exactly one clk later.
- Loader stall:
  - ld_valid toggled 1,0,1 with ld_last on 2nd valid beat.
  - Only 2 beats counted; ld_valid=0 cycle writes nothing; RUN entered after 2nd valid beat.
- Reload:
  - In RUN, pulse reload_req.
  - Next cycle inst_busy=1, ld_count=0, inst_data=NOP from the following cycle.
  - Reload addr 0x004 with 0xDEADBEEF+ld_last; fetch 0x004 -> 0xDEADBEEF; fetch 0x000 -> 0x11111111 (retained).
- Misaligned fetch:
  - In RUN, inst_addr=0x00A -> inst_data=mem word 2, inst_misalign=1.
  - inst_addr=0x00C next -> inst_misalign=0.
- Parity and mid-load reset (with INST_MEM_PARITY_EN):
  - Force stored parity bit of word 1 flipped; fetch 0x004 -> inst_parity_err=1 for one cycle, data unchanged.
  - Separately, assert rst_n=0 after 2 of 4 beats -> ld_count=0, state LOAD, inst_busy=1.
